// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : i2c_arb_pkg
// Description : Shared types, widths and round-robin pick for the I2C arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;
    localparam int MAX_NREQ   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // One-hot pick of the first active request after `last`, wrapping modulo nreq.
    function automatic logic [MAX_NREQ-1:0] rr_next(
        input logic [MAX_NREQ-1:0] req,
        input logic [2:0]          last,
        input int                  nreq
    );
        logic [MAX_NREQ-1:0] grant;
        logic                found;
        int                  idx;
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_NREQ; i++) begin
            if (i <= nreq) begin
                idx = (int'(last) + i) % nreq;
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick with a registered last pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic                    grant_en,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx
);

    localparam int c_IDX_W = $clog2(NREQ);

    logic [c_IDX_W-1:0]  r_last;
    logic [MAX_NREQ-1:0] w_req_ext;
    logic [MAX_NREQ-1:0] w_grant_ext;
    logic [2:0]          w_last_ext;
    logic [c_IDX_W-1:0]  w_idx;

    always_comb begin
        w_req_ext                 = '0;
        w_req_ext[NREQ-1:0]       = req;
        w_last_ext                = '0;
        w_last_ext[c_IDX_W-1:0]   = r_last;
        w_grant_ext               = rr_next(w_req_ext, w_last_ext, NREQ);
        w_idx                     = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            if (w_grant_ext[k]) begin
                w_idx = c_IDX_W'(k);
            end
        end
    end

    assign grant     = w_grant_ext[NREQ-1:0];
    assign grant_idx = w_idx;

    // Reset to the highest index so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= c_IDX_W'(NREQ - 1);
        end else if (grant_en && (|req)) begin
            r_last <= w_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master_arbiter
// Description : Round-robin sharing of one I2C master between NREQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int NEWD_CYCLES    = 24,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0]              req_wr,
    input  logic [I2C_ADDR_W*NREQ-1:0]   req_addr,
    input  logic [I2C_DATA_W*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]              rsp_ack,
    output logic [NREQ-1:0]              rsp_err,
    output logic [I2C_DATA_W-1:0]        rsp_rdata,
    output logic                         busy,
    output logic                         m_newd,
    output logic                         m_wr,
    output logic [I2C_ADDR_W-1:0]        m_addr,
    output logic [I2C_DATA_W-1:0]        m_wdata,
    input  logic [I2C_DATA_W-1:0]        m_rdata,
    input  logic                         m_done
);

    localparam int c_IDX_W = $clog2(NREQ);
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);

    arb_state_t              r_state;
    arb_state_t              w_next;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [NREQ-1:0]         w_grant;
    logic [c_IDX_W-1:0]      w_grant_idx;
    logic [c_IDX_W-1:0]      r_idx;
    logic                    w_grant_en;
    logic                    r_done_s1;
    logic                    r_done_s2;
    logic                    r_done_s3;
    logic                    r_done_rise;
    logic                    w_done_edge;
    logic                    w_launch_end;
    logic                    w_timeout;
    logic                    w_sel_wr;
    logic [I2C_ADDR_W-1:0]   w_sel_addr;
    logic [I2C_DATA_W-1:0]   w_sel_wdata;
    logic                    r_m_newd;
    logic                    r_m_wr;
    logic [I2C_ADDR_W-1:0]   r_m_addr;
    logic [I2C_DATA_W-1:0]   r_m_wdata;
    logic [NREQ-1:0]         r_rsp_ack;
    logic [NREQ-1:0]         r_rsp_err;
    logic [I2C_DATA_W-1:0]   r_rsp_rdata;

    rr_arbiter #(
        .NREQ      (NREQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant_en  (w_grant_en),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_grant_en   = (r_state == IDLE) && (|req);
    assign w_launch_end = (r_cnt == c_CNT_W'(NEWD_CYCLES - 1));
    assign w_timeout    = (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_done_edge  = r_done_rise && (r_state == WAIT);

    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                w_sel_wr    = req_wr[k];
                w_sel_addr  = req_addr[k*I2C_ADDR_W +: I2C_ADDR_W];
                w_sel_wdata = req_wdata[k*I2C_DATA_W +: I2C_DATA_W];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|req) w_next = LAUNCH;
            LAUNCH:  if (w_launch_end) w_next = WAIT;
            WAIT:    if (w_done_edge || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == LAUNCH) || (r_state == WAIT)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // m_done comes from the master's derived clock; the rise is registered once more.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_s1   <= 1'b0;
            r_done_s2   <= 1'b0;
            r_done_s3   <= 1'b0;
            r_done_rise <= 1'b0;
        end else begin
            r_done_s1   <= m_done;
            r_done_s2   <= r_done_s1;
            r_done_s3   <= r_done_s2;
            r_done_rise <= r_done_s2 & ~r_done_s3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_newd    <= 1'b0;
            r_m_wr      <= 1'b0;
            r_m_addr    <= '0;
            r_m_wdata   <= '0;
            r_idx       <= '0;
            r_rsp_ack   <= '0;
            r_rsp_err   <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_m_newd  <= (w_next == LAUNCH);
            r_rsp_ack <= '0;
            r_rsp_err <= '0;
            if (w_grant_en) begin
                r_idx     <= w_grant_idx;
                r_m_wr    <= w_sel_wr;
                r_m_addr  <= w_sel_addr;
                r_m_wdata <= w_sel_wdata;
            end
            // A done edge coinciding with the timeout still counts as success.
            if ((r_state == WAIT) && (w_next == RESP)) begin
                if (w_done_edge) begin
                    r_rsp_ack[r_idx] <= 1'b1;
                    if (!r_m_wr) begin
                        r_rsp_rdata <= m_rdata;
                    end
                end else begin
                    r_rsp_err[r_idx] <= 1'b1;
                end
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign m_newd    = r_m_newd;
    assign m_wr      = r_m_wr;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign rsp_ack   = r_rsp_ack;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_master_arbiter
// Description : Directed self-checking bench for i2c_master_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_wr;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  rsp_ack;
    logic [3:0]  rsp_err;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic        m_newd;
    logic        m_wr;
    logic [6:0]  m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;
    logic        m_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    i2c_master_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_ack   (rsp_ack),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .m_newd    (m_newd),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_done    (m_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_newd(input logic lvl, input int bound);
        int n = 0;
        while (m_newd !== lvl && n < bound) begin
            tick();
            n++;
        end
        if (m_newd !== lvl) check("newd_wait", 32'(m_newd), 32'(lvl));
    endtask

    task automatic wait_resp(input int bound, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while ((rsp_ack | rsp_err) == 4'd0 && lat < bound);
        if ((rsp_ack | rsp_err) == 4'd0) check("resp_wait", 32'(|{rsp_ack, rsp_err}), 32'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = '0; m_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic do_txn(input int k, input logic wr, input logic [6:0] addr,
                          input logic [7:0] wd, input logic [7:0] rd, input logic hold_done);
        int width;
        int lat;
        req_wr[k] = wr;
        req_addr[k*7 +: 7] = addr;
        req_wdata[k*8 +: 8] = wd;
        m_rdata = rd;
        req[k] = 1'b1;
        tick();
        check("newd_rise", 32'(m_newd), 32'd1);
        check("m_addr", 32'(m_addr), 32'(addr));
        check("m_wdata", 32'(m_wdata), 32'(wd));
        check("m_wr", 32'(m_wr), 32'(wr));
        width = 0;
        while (m_newd && width < 100) begin
            width++;
            tick();
        end
        check("newd_width", 32'(width), 32'd24);
        repeat (3) tick();
        m_done = 1'b1;
        wait_resp(50, lat);
        check("done_lat", 32'(lat), 32'd4);
        check("ack", 32'(rsp_ack), 32'(1 << k));
        check("err", 32'(rsp_err), 32'd0);
        req[k] = 1'b0;
        if (!hold_done) m_done = 1'b0;
        tick();
        check("ack_pulse", 32'(rsp_ack), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        int exp_k;
        rst = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        m_rdata = '0; m_done = 1'b0;
        apply_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_newd", 32'(m_newd), 32'd0);
        check("rst_addr", 32'(m_addr), 32'd0);
        check("rst_wdata", 32'(m_wdata), 32'd0);
        check("rst_wr", 32'(m_wr), 32'd0);
        check("rst_ack", 32'(rsp_ack), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);

        // Round robin: all four held high, grants 0,1,2,3,0.
        for (int k = 0; k < 4; k++) begin
            req_addr[k*7 +: 7]  = 7'(7'h10 + k);
            req_wdata[k*8 +: 8] = 8'(8'hA0 + k);
        end
        req_wr = 4'b1111;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_k = i % 4;
            wait_newd(1'b1, 10);
            check("rr_addr", 32'(m_addr), 32'(7'h10 + exp_k));
            wait_newd(1'b0, 40);
            m_done = 1'b1;
            wait_resp(50, lat);
            check("rr_ack", 32'(rsp_ack), 32'(1 << exp_k));
            m_done = 1'b0;
            if (i == 4) req = '0;
        end
        tick();
        tick();

        do_txn(0, 1'b1, 7'h50, 8'hA5, 8'h00, 1'b0);
        do_txn(2, 1'b0, 7'h51, 8'h00, 8'h3C, 1'b0);
        check("rd_data", 32'(rsp_rdata), 32'h3C);
        do_txn(1, 1'b1, 7'h22, 8'h77, 8'h99, 1'b0);
        check("rd_hold", 32'(rsp_rdata), 32'h3C);

        // Timeout: no done at all.
        req_wr[3] = 1'b1; req_addr[21 +: 7] = 7'h33; m_done = 1'b0;
        req[3] = 1'b1;
        wait_resp(25000, lat);
        check("to_lat", 32'(lat), 32'd20025);
        check("to_err", 32'(rsp_err), 32'h8);
        check("to_ack", 32'(rsp_ack), 32'd0);
        req[3] = 1'b0;
        tick();
        check("to_busy", 32'(busy), 32'd0);

        // Done edge lands on the same cycle as the timeout.
        req[3] = 1'b1;
        repeat (20021) tick();
        m_done = 1'b1;
        wait_resp(50, lat);
        check("coin_lat", 32'(lat), 32'd4);
        check("coin_ack", 32'(rsp_ack), 32'h8);
        check("coin_err", 32'(rsp_err), 32'd0);
        req[3] = 1'b0; m_done = 1'b0;
        repeat (2) tick();

        // Stale done: left high after the previous ack.
        do_txn(0, 1'b1, 7'h44, 8'h11, 8'h00, 1'b1);
        req[0] = 1'b1;
        wait_newd(1'b1, 10);
        wait_newd(1'b0, 40);
        seen = 0;
        repeat (10) begin
            tick();
            if ((rsp_ack | rsp_err) != 4'd0) seen++;
        end
        check("stale_none", 32'(seen), 32'd0);
        m_done = 1'b0;
        repeat (2) tick();
        m_done = 1'b1;
        wait_resp(50, lat);
        check("stale_lat", 32'(lat), 32'd4);
        check("stale_ack", 32'(rsp_ack), 32'h1);
        req[0] = 1'b0; m_done = 1'b0;
        repeat (2) tick();

        // Reset during WAIT.
        req_addr[7 +: 7] = 7'h21;
        req[1] = 1'b1;
        wait_newd(1'b1, 10);
        wait_newd(1'b0, 40);
        repeat (5) tick();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_newd", 32'(m_newd), 32'd0);
        check("mr_addr", 32'(m_addr), 32'd0);
        check("mr_wdata", 32'(m_wdata), 32'd0);
        check("mr_wr", 32'(m_wr), 32'd0);
        check("mr_rdata", 32'(rsp_rdata), 32'd0);
        check("mr_pulse", 32'(rsp_ack | rsp_err), 32'd0);
        m_done = 1'b1;
        seen = 0;
        repeat (6) begin
            tick();
            if ((rsp_ack | rsp_err) != 4'd0) seen++;
        end
        check("mr_no_pulse", 32'(seen), 32'd0);
        m_done = 1'b0;
        req_addr[14 +: 7] = 7'h52;
        req = 4'b0110;
        wait_newd(1'b1, 10);
        check("mr_last", 32'(m_addr), 32'h21);
        req = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
